// File: rtl/dmem_sized_if.sv
// rtl/dmem_sized_if.sv - request/response bus between the CPU datapath and dmem_sized
interface dmem_sized_if #(
  parameter int ADDR_W = 10
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              misalign;
  logic              busy;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, rvalid, misalign, busy
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, rvalid, misalign, busy
  );
endinterface

// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - byte/half/word data memory with registered loads, clear sequencer, debug port; optional store trace under DMEM_TRACE_EN
module dmem_sized #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 10,
  parameter int CLR_ON_RST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dmem_sized_if.slave              bus,
  input  logic [$clog2(DEPTH)-1:0] dbg_sel,
  output logic [31:0]              dbg_data
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  logic [31:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             misalign_q, misalign_d;

  logic [IDX_W-1:0] word_idx;
  logic [31:0]      cur_word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic             aligned, accept, store, load;
  logic [31:0]      load_val;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_mask;

  // Decode the request: alignment, lane extraction and extension of the load result
  always_comb begin
    word_idx = bus.addr[IDX_W+1:2];
    cur_word = mem[word_idx];
    byte_v   = cur_word[{bus.addr[1:0], 3'b000} +: 8];
    half_v   = cur_word[{bus.addr[1], 4'b0000} +: 16];
    unique case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.addr[0];
      2'b10:   aligned = (bus.addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    accept = bus.req && (state_q == S_IDLE);
    store  = accept && bus.we && aligned;
    load   = accept && !bus.we && aligned;
    unique case (bus.size)
      2'b00:   load_val = {{24{bus.sign_ext & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{bus.sign_ext & half_v[15]}}, half_v};
      default: load_val = cur_word;
    endcase
  end

  // Select the array write: the clear sequencer owns the port while clearing
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_data = bus.wdata;
    wr_mask = 4'b0000;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_data = 32'h0;
      wr_mask = 4'b1111;
    end else if (store) begin
      wr_en = 1'b1;
      unique case (bus.size)
        2'b00: begin
          wr_data = {4{bus.wdata[7:0]}};
          wr_mask = 4'b0001 << bus.addr[1:0];
        end
        2'b01: begin
          wr_data = {2{bus.wdata[15:0]}};
          wr_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wr_data = bus.wdata;
          wr_mask = 4'b1111;
        end
      endcase
    end
  end

  // Next-state: clear walk over every word, then registered load/misalign results
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = load;
    misalign_d = accept && !aligned;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = S_IDLE;
      end
    end
    if (load) begin
      rdata_d = load_val;
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      cnt_q      <= '0;
      rdata_q    <= 32'h0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage array with per-lane write enables; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_TRACE_EN
  // Trace each accepted store with the first words of the array
  always @(posedge clk) begin
    if (rst_n && store) begin
      $write("dmem store addr=%h wdata=%h mask=%b words:", bus.addr, bus.wdata, wr_mask);
      for (int i = 0; i < 8 && i < DEPTH; i++) begin
        $write(" %h", mem[i]);
      end
      $write("\n");
    end
  end
`else
  // No store trace in this build
`endif

  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.misalign = misalign_q;
  assign bus.busy     = (state_q == S_CLEAR);
  assign dbg_data     = mem[dbg_sel];
endmodule

// File: tb/tb_dmem_sized.sv
// tb/tb_dmem_sized.sv - directed and randomized checks of dmem_sized against a byte-array model
module tb_dmem_sized;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 11;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  dbg_sel;
  logic [31:0] dbg_data;

  dmem_sized_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_sized #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLR_ON_RST(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  logic [7:0]  mdl [NBYTES];
  logic [31:0] exp_rdata;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {mdl[4*idx+3], mdl[4*idx+2], mdl[4*idx+1], mdl[4*idx]};
  endfunction

  // One request cycle: predict from the model, apply, check the following cycle
  task automatic op(input bit we, input logic [1:0] sz, input bit sx,
                    input int a, input logic [31:0] wd, input string tag);
    int          base, nb;
    bit          al;
    logic [31:0] val;
    base = a % NBYTES;
    al   = (sz == 2'd0) || (sz == 2'd1 && a % 2 == 0) || (sz == 2'd2 && a % 4 == 0);
    nb   = 1 << sz;
    if (al && !we) begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val = val | (32'(mdl[base+i]) << (8*i));
      if (sx && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      exp_rdata = val;
    end
    bus.req = 1'b1; bus.we = we; bus.size = sz; bus.sign_ext = sx;
    bus.addr = ADDR_W'(a); bus.wdata = wd;
    @(posedge clk); #1;
    bus.req = 1'b0;
    if (al && we) begin
      for (int i = 0; i < nb; i++) mdl[base+i] = wd[8*i +: 8];
    end
    chk({tag, ".rvalid"}, {31'b0, bus.rvalid}, {31'b0, al && !we});
    chk({tag, ".misalign"}, {31'b0, bus.misalign}, {31'b0, !al});
    chk({tag, ".rdata"}, bus.rdata, exp_rdata);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic dbg_chk(input int idx, input logic [31:0] exp, input string tag);
    dbg_sel = 8'(idx); #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    int n, m, a, sel;
    logic [1:0] sz;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = 32'h0; dbg_sel = 8'h0;
    exp_rdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst.rdata", bus.rdata, 32'h0);
    chk("rst.rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("rst.misalign", {31'b0, bus.misalign}, 32'h0);
    chk("rst.busy", {31'b0, bus.busy}, 32'h1);

    // Clear sequence length
    @(posedge clk); #1; rst_n = 1'b1;
    count_busy(n);
    chk("clear.cycles", n, 256);
    model_clear();
    dbg_chk(5, 32'h0, "clear.dbg5");

    // Word store then word/byte loads
    op(1, 2'd2, 0, 'h10, 32'h1234_5678, "sw10");
    op(0, 2'd2, 0, 'h10, 32'h0, "lw10");
    chk("lw10.const", bus.rdata, 32'h1234_5678);
    op(0, 2'd0, 0, 'h11, 32'h0, "lbu11");
    chk("lbu11.const", bus.rdata, 32'h0000_0056);

    // Byte store with sign/zero extension
    op(1, 2'd0, 0, 'h13, 32'h80, "sb13");
    op(0, 2'd0, 1, 'h13, 32'h0, "lb13");
    chk("lb13.const", bus.rdata, 32'hFFFF_FF80);
    op(0, 2'd0, 0, 'h13, 32'h0, "lbu13");
    chk("lbu13.const", bus.rdata, 32'h0000_0080);
    dbg_chk(4, 32'h8034_5678, "dbg4");

    // Half-word lanes
    op(1, 2'd2, 0, 'h20, 32'h0, "sw20");
    op(1, 2'd1, 0, 'h22, 32'hBEEF, "sh22");
    op(0, 2'd2, 0, 'h20, 32'h0, "lw20");
    chk("lw20.const", bus.rdata, 32'hBEEF_0000);
    op(0, 2'd1, 1, 'h22, 32'h0, "lh22");
    chk("lh22.const", bus.rdata, 32'hFFFF_BEEF);
    op(0, 2'd1, 0, 'h22, 32'h0, "lhu22");
    chk("lhu22.const", bus.rdata, 32'h0000_BEEF);

    // Misaligned requests leave memory alone and pulse for one cycle
    op(0, 2'd2, 0, 'h21, 32'h0, "lw21");
    op(1, 2'd1, 0, 'h23, 32'h1111, "sh23");
    @(posedge clk); #1;
    chk("misalign.pulse", {31'b0, bus.misalign}, 32'h0);
    op(1, 2'd3, 0, 'h24, 32'h2222, "size11");
    dbg_chk(8, 32'hBEEF_0000, "dbg8");

    // Randomized traffic, including wrap-around and illegal sizes
    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((1 << sz) - 1);
      if (k % 16 == 0) a = (a % 64) + 2 * NBYTES * ($urandom_range(0, 1));
      op(bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)), a, $urandom, "rnd");
      if (k % 5 == 0) begin
        sel = int'($urandom_range(0, DEPTH - 1));
        dbg_chk(sel, model_word(sel), "rnd.dbg");
      end
      if (k % 7 == 0) begin
        @(posedge clk); #1;
        chk("rnd.idle_rvalid", {31'b0, bus.rvalid}, 32'h0);
      end
    end

    // Reset during clear restarts the sequence; requests while busy are dropped
    op(0, 2'd2, 0, 'h10, 32'h0, "pre_rst_lw");
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (100) @(posedge clk); #1;
    chk("clr100.busy", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0; #1;
    chk("midrst.busy", {31'b0, bus.busy}, 32'h1);
    chk("midrst.rdata", bus.rdata, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = ADDR_W'('h40);
    bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk("busy_drop.rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("busy_drop.misalign", {31'b0, bus.misalign}, 32'h0);
    count_busy(m);
    n = m + 1;
    chk("reclear.cycles", n, 256);
    model_clear();
    exp_rdata = 32'h0;
    dbg_chk(16, 32'h0, "busy_drop.dbg16");
    op(1, 2'd2, 0, 'h404, 32'h0000_00A5, "sw404");
    dbg_chk(1, 32'h0000_00A5, "wrap.dbg1");
    op(0, 2'd2, 0, 'h004, 32'h0, "lw004");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
